// File: rtl/cpu_pkg.sv
// Shared RV32I encoding constants, request/error types and the loader state type.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ERR_W = 2;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_LW_SW   = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [OP_W-1:0] {
        OP_ADD, OP_SUB, OP_OR, OP_AND, OP_ADDI, OP_LW, OP_SW, OP_BEQ
    } op_t;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE      = 2'b00,
        ERR_IMM_RANGE = 2'b01,
        ERR_BR_ALIGN  = 2'b10,
        ERR_OVERFLOW  = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        ST_LOAD, ST_FULL, ST_DONE, ST_ERR
    } ld_state_t;

    typedef struct packed {
        op_t              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic             last;
    } inst_req_t;

    // Signed inclusive range test on a 32-bit immediate.
    function automatic logic imm_in_range(input logic [XLEN-1:0] imm,
                                          input logic signed [XLEN-1:0] lo,
                                          input logic signed [XLEN-1:0] hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/inst_enc_comb.sv
// Combinational RV32I encoder: builds the instruction word and flags illegal immediates.
module inst_enc_comb
    import cpu_pkg::*;
(
    input  op_t              op_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic [XLEN-1:0]  imm_i,
    output logic [XLEN-1:0]  word_o,
    output err_t             err_code_o
);

    always_comb begin
        word_o     = '0;
        err_code_o = ERR_NONE;
        case (op_i)
            OP_ADD: word_o = {F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OPC_R};
            OP_SUB: word_o = {F7_SUB,  rs2_i, rs1_i, F3_ADD_SUB, rd_i, OPC_R};
            OP_OR:  word_o = {F7_BASE, rs2_i, rs1_i, F3_OR,      rd_i, OPC_R};
            OP_AND: word_o = {F7_BASE, rs2_i, rs1_i, F3_AND,     rd_i, OPC_R};
            OP_ADDI: begin
                word_o = {imm_i[11:0], rs1_i, F3_ADD_SUB, rd_i, OPC_OP_IMM};
                if (!imm_in_range(imm_i, -32'sd2048, 32'sd2047)) err_code_o = ERR_IMM_RANGE;
            end
            OP_LW: begin
                word_o = {imm_i[11:0], rs1_i, F3_LW_SW, rd_i, OPC_LOAD};
                if (!imm_in_range(imm_i, -32'sd2048, 32'sd2047)) err_code_o = ERR_IMM_RANGE;
            end
            OP_SW: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, F3_LW_SW, imm_i[4:0], OPC_STORE};
                if (!imm_in_range(imm_i, -32'sd2048, 32'sd2047)) err_code_o = ERR_IMM_RANGE;
            end
            OP_BEQ: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                          imm_i[4:1], imm_i[11], OPC_BRANCH};
                // Range violation takes precedence over misalignment.
                if (!imm_in_range(imm_i, -32'sd4096, 32'sd4094)) err_code_o = ERR_IMM_RANGE;
                else if (imm_i[0])                                err_code_o = ERR_BR_ALIGN;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: accepts instruction requests, encodes them and writes imem sequentially.
module inst_encoder
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [REG_W-1:0]  req_rd,
    input  logic [REG_W-1:0]  req_rs1,
    input  logic [REG_W-1:0]  req_rs2,
    input  logic [XLEN-1:0]   req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    input  logic              imem_ready,
    output logic              done,
    output logic              err,
    output logic [ERR_W-1:0]  err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    ld_state_t         state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_t              code_q, code_d;
    logic [ADDR_W:0]   count_q, count_d;

    inst_req_t         req;
    logic [XLEN-1:0]   enc_word;
    err_t              enc_err;
    logic              wr_fire;
    logic              wr_blocked;
    logic              accept;

    assign req = '{op: op_t'(req_op), rd: req_rd, rs1: req_rs1, rs2: req_rs2,
                   imm: req_imm, last: req_last};

    inst_enc_comb u_enc (
        .op_i       (req.op),
        .rd_i       (req.rd),
        .rs1_i      (req.rs1),
        .rs2_i      (req.rs2),
        .imm_i      (req.imm),
        .word_o     (enc_word),
        .err_code_o (enc_err)
    );

    // A pending last word or top-of-memory word ends loading, so nothing may be queued behind it.
    assign wr_fire    = we_q && imem_ready;
    assign wr_blocked = we_q && (last_q || (addr_q == ADDR_TOP));
    assign req_ready  = (state_q == ST_LOAD) && !wr_blocked && (!we_q || imem_ready);
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        count_d = count_q;
        case (state_q)
            ST_LOAD: begin
                if (wr_fire) begin
                    we_d    = 1'b0;
                    count_d = count_q + (ADDR_W+1)'(1);
                    if (addr_q != ADDR_TOP) addr_d = addr_q + ADDR_W'(1);
                    if (last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (addr_q == ADDR_TOP) begin
                        state_d = ST_FULL;
                    end
                end
                if (accept) begin
                    if (enc_err != ERR_NONE) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        code_d  = enc_err;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = enc_word;
                        last_d  = req.last;
                    end
                end
            end
            ST_FULL: begin
                if (req_valid) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    code_d  = ERR_OVERFLOW;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    count_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign count      = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: single-instruction vector table plus stall/full/reset sequences.
module tb_inst_encoder;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, req_valid, sel_b, req_last, imem_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;

    logic        a_ready, a_we, a_done, a_err;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_code;
    logic [6:0]  a_count;

    logic        b_ready, b_we, b_done, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [1:0]  b_code;
    logic [2:0]  b_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_encoder dut_a (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid && !sel_b), .req_ready(a_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .imem_ready(imem_ready),
        .done(a_done), .err(a_err), .err_code(a_code), .count(a_count)
    );

    inst_encoder #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid && sel_b), .req_ready(b_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .imem_ready(imem_ready),
        .done(b_done), .err(b_err), .err_code(b_code), .count(b_count)
    );

    typedef struct {
        op_t         op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    // Present one request and hold it until the selected instance accepts it; returns on the next negedge.
    task automatic issue(input op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        bit ok;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_last = last;
        req_valid = 1'b1;
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (sel_b ? b_ready : a_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        req_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout op=%0d", op);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 2'b00};
        vecs[1]  = '{OP_OR,   5'd4, 5'd1, 5'd2, 32'd0,        32'h0020E233, 2'b00};
        vecs[2]  = '{OP_AND,  5'd4, 5'd1, 5'd2, 32'h123,      32'h0020F233, 2'b00};
        vecs[3]  = '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 2'b00};
        vecs[4]  = '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2047,     32'h7FF00093, 2'b00};
        vecs[5]  = '{OP_LW,   5'd1, 5'd0, 5'd0, -32'sd2048,   32'h80002083, 2'b00};
        vecs[6]  = '{OP_SW,   5'd0, 5'd2, 5'd5, 32'hFFFFFFFF, 32'hFE512FA3, 2'b00};
        vecs[7]  = '{OP_BEQ,  5'd0, 5'd1, 5'd2, -32'sd8,      32'hFE208CE3, 2'b00};
        vecs[8]  = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd4094,     32'h7E208FE3, 2'b00};
        vecs[9]  = '{OP_BEQ,  5'd0, 5'd1, 5'd2, -32'sd4096,   32'h80208063, 2'b00};
        vecs[10] = '{OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h0,        2'b01};
        vecs[11] = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,        32'h0,        2'b10};
        vecs[12] = '{OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd4096,     32'h0,        2'b01};
        vecs[13] = '{OP_SW,   5'd0, 5'd2, 5'd5, -32'sd2049,   32'h0,        2'b01};

        reset = 1'b0; start = 1'b0; req_valid = 1'b0; sel_b = 1'b0; req_last = 1'b0;
        imem_ready = 1'b1; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_we", a_we, 0);       chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);     chk("rst_code", a_code, 0);
        chk("rst_count", a_count, 0); chk("rst_addr", a_addr, 0);
        chk("rst_ready", a_ready, 1);
        @(negedge clk);

        // Each vector is a one-instruction program followed by a restart.
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1);
            if (vecs[i].code == 2'b00) begin
                chk($sformatf("v%0d_we", i), a_we, 1);
                chk($sformatf("v%0d_addr", i), a_addr, 0);
                chk($sformatf("v%0d_wdata", i), a_wdata, vecs[i].word);
                @(negedge clk);
                chk($sformatf("v%0d_done", i), a_done, 1);
                chk($sformatf("v%0d_count", i), a_count, 1);
                chk($sformatf("v%0d_we_clr", i), a_we, 0);
                chk($sformatf("v%0d_ready_done", i), a_ready, 0);
                chk($sformatf("v%0d_err", i), a_err, 0);
            end else begin
                chk($sformatf("v%0d_err", i), a_err, 1);
                chk($sformatf("v%0d_code", i), a_code, 32'(vecs[i].code));
                chk($sformatf("v%0d_no_we", i), a_we, 0);
                chk($sformatf("v%0d_count", i), a_count, 0);
                chk($sformatf("v%0d_ready_err", i), a_ready, 0);
            end
            pulse_start();
            chk($sformatf("v%0d_st_err", i), a_err, 0);
            chk($sformatf("v%0d_st_done", i), a_done, 0);
            chk($sformatf("v%0d_st_count", i), a_count, 0);
            chk($sformatf("v%0d_st_addr", i), a_addr, 0);
            chk($sformatf("v%0d_st_ready", i), a_ready, 1);
        end

        // ADD then SUB back to back.
        issue(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("add_wdata", a_wdata, 32'h002081B3);
        chk("add_addr", a_addr, 0);
        issue(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        chk("sub_we", a_we, 1);
        chk("sub_wdata", a_wdata, 32'h402081B3);
        chk("sub_addr", a_addr, 1);
        chk("sub_count1", a_count, 1);
        @(negedge clk);
        chk("sub_done", a_done, 1);
        chk("sub_count2", a_count, 2);
        pulse_start();

        // LW stalled by imem for three cycles while SW waits.
        imem_ready = 1'b0;
        issue(OP_LW, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0);
        req_op = OP_SW; req_rd = 5'd0; req_rs1 = 5'd2; req_rs2 = 5'd5; req_imm = 32'd12;
        req_last = 1'b1; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_ready", k), a_ready, 0);
            chk($sformatf("stall%0d_we", k), a_we, 1);
            chk($sformatf("stall%0d_wdata", k), a_wdata, 32'h00812283);
            chk($sformatf("stall%0d_addr", k), a_addr, 0);
            @(negedge clk);
        end
        imem_ready = 1'b1;
        issue(OP_SW, 5'd0, 5'd2, 5'd5, 32'd12, 1'b1);
        chk("sw_wdata", a_wdata, 32'h00512623);
        chk("sw_addr", a_addr, 1);
        chk("sw_count", a_count, 1);
        @(negedge clk);
        chk("sw_done", a_done, 1);
        chk("sw_count2", a_count, 2);
        pulse_start();

        // Fill the 4-word instance, then overflow it.
        sel_b = 1'b1;
        for (int k = 1; k <= 4; k++) issue(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(k), 1'b0);
        chk("fill_we", b_we, 1);
        chk("fill_addr", b_addr, 3);
        chk("fill_wdata", b_wdata, 32'h00400093);
        @(negedge clk);
        chk("full_count", b_count, 4);
        chk("full_we", b_we, 0);
        chk("full_ready", b_ready, 0);
        chk("full_err", b_err, 0);
        chk("full_done", b_done, 0);
        chk("full_addr", b_addr, 3);
        pulse_start();
        chk("full_start_ign_count", b_count, 4);
        chk("full_start_ign_ready", b_ready, 0);
        chk("full_start_ign_err", b_err, 0);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ovf_err", b_err, 1);
        chk("ovf_code", b_code, 3);
        chk("ovf_count", b_count, 4);
        chk("ovf_done", b_done, 0);

        // Reset while a write is stalled drops it.
        pulse_start();
        chk("b_restart_err", b_err, 0);
        imem_ready = 1'b0;
        issue(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        chk("b_stall_we", b_we, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", b_we, 0);
        chk("mid_rst_count", b_count, 0);
        chk("mid_rst_addr", b_addr, 0);
        reset = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", b_ready, 1);
        chk("post_rst_a_we", a_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
